mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the yIF/yPC/yID/yEX/yDM/yWB datapath; replaces inline bench decode.
//  Decodes ins[31:26]/ins[5:0] and drives RegDst/RegWrite/ALUSrc/Mem2Reg/MemRead/MemWrite/op.
//  Also drives branch/jump/INT and a PC enable, one state per datapath phase.
//  Runs MAX_INS instructions from ENTRY_POINT after start, then reports done.
// PARAMETERS
//  MAX_INS      43   instructions retired per run (1..2^CNT_W-1)
//  CNT_W        16   width of retire counter
//  ENTRY_POINT  128  byte address loaded into PC at boot (drives entryPoint)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      level; sampled only in IDLE/DONE, starts a run
//  ins          in   32     current instruction from yIF
//  zero         in   1      ALU zero from yEX (informational; yPC resolves beq)
//  RegDst       out  1      rd (1) / rt (0) destination select
//  RegWrite     out  1      register-file write strobe
//  ALUSrc       out  1      immediate (1) / rd2 (0) ALU operand
//  Mem2Reg      out  1      write-back memOut (1) / z (0)
//  MemRead      out  1      data-memory read enable
//  MemWrite     out  1      data-memory write strobe
//  op           out  3      ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//  branch       out  1      beq in flight
//  jump         out  1      j in flight
//  INT          out  1      PC load of entryPoint
//  entryPoint   out  32     constant ENTRY_POINT
//  pc_en        out  1      one-cycle PC update strobe (instruction retire)
//  busy         out  1      high from BOOT until DONE
//  done         out  1      high in DONE
//  illegal      out  1      sticky: unsupported opcode/funct seen this run
//  ins_count    out  CNT_W  instructions retired this run
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; every output 0 except op=010, entryPoint=ENTRY_POINT.
//  States: IDLE, BOOT, FETCH, DECODE, EXEC, MEM, WB, DONE.
//  IDLE/DONE + start=1 -> BOOT: clear ins_count and illegal; done=0.
//  BOOT: INT=1, pc_en=1 for exactly 1 cycle -> FETCH.
//  FETCH -> DECODE; all controls at defaults (RegDst0 RegWrite0 ALUSrc1 op010, rest 0).
//  DECODE: latch decoded controls into a register, held until retire.
//   R (op 0): RegDst1 ALUSrc0; funct 20 add, 22 sub, 24 and, 25 or, 2a slt; path EXEC->WB.
//   lw (23): ALUSrc1 MemRead1 Mem2Reg1; path EXEC->MEM->WB.
//   sw (2b): ALUSrc1; path EXEC->MEM (MemWrite=1 in MEM only).
//   beq (04): ALUSrc0 op110 branch1; path EXEC, retire there.
//   addi (08): ALUSrc1 op010; path EXEC->WB.
//   j (02): jump1; retire in DECODE.
//   other opcode/funct: illegal<=1; retire in DECODE as NOP (no strobes).
//  Strobes: RegWrite only in WB; MemWrite only in MEM; MemRead in MEM for lw.
//  Retire (last state of the instruction path): pc_en=1 for 1 cycle; ins_count+=1.
//  After retire: ins_count==MAX_INS -> DONE, else -> FETCH.
//  Latency in cycles, FETCH..retire: j/NOP 2, beq 3, R/addi 4, sw 4, lw 5.
//  Limits: pc_en/INT never both high outside BOOT; ins_count saturates at MAX_INS.
//  Limits: start ignored while busy; start held high in DONE restarts immediately.
//  Reset mid-instruction aborts with no strobe; no partial write is issued after rst_n rises.
// TESTING
//  T1 reset: rst_n=0 mid-WB -> same-cycle RegWrite=0, pc_en=0, state IDLE, busy=0.
//  T2 boot: start=1 -> next cycle INT=1, pc_en=1, entryPoint=128; then FETCH, INT=0.
//  T3 add 0x00851020 -> RegDst1 ALUSrc0 op010; RegWrite=1 only in cycle 4; pc_en in cycle 4.
//  T4 lw 0x8C820004 -> MemRead1 Mem2Reg1 ALUSrc1; RegWrite in cycle 5.
//  T4 sw 0xAC820004 -> MemWrite 1 cycle, RegWrite never.
//  T5 beq 0x10A4FFFE -> branch1 op110, retire cycle 3; j 0x08000020 -> jump1, retire cycle 2.
//  T5 opcode 0x3F -> illegal=1 sticky, no strobes, ins_count+1.
//  T6 MAX_INS=3 with add,or,j -> done=1 after 3rd pc_en, ins_count=3.
//  T6 start re-pulsed -> count 0, illegal 0.

Source files
------------

// File: rtl/mips_ctrl_if.sv
// Control/datapath bundle between the multi-cycle sequencer and the yIF/yPC/yID/yEX/yDM/yWB datapath.
interface mips_ctrl_if;
  logic [31:0] ins;
  logic        zero;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic        Mem2Reg;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  op;
  logic        branch;
  logic        jump;
  logic        INT;
  logic [31:0] entryPoint;
  logic        pc_en;

  modport master (
    input  ins, zero,
    output RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op,
    output branch, jump, INT, entryPoint, pc_en
  );

  modport slave (
    output ins, zero,
    input  RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op,
    input  branch, jump, INT, entryPoint, pc_en
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer: one state per datapath phase, runs MAX_INS instructions from ENTRY_POINT.
// Controls are registered; each cycle's values are computed from the state being entered.
module mips_multicycle_ctrl #(
  parameter int unsigned MAX_INS     = 43,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ENTRY_POINT = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  mips_ctrl_if.master      bus,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] ins_count
);

  localparam int unsigned CW1 = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_e;

  typedef enum logic [2:0] {K_NOP, K_JUMP, K_BEQ, K_ALU, K_SW, K_LW} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       reg_dst;
    logic       alu_src;
    logic       mem2reg;
    logic [2:0] op;
    logic       branch;
    logic       jump;
    logic       bad;
  } dec_t;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem2reg;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] op;
    logic       branch;
    logic       jump;
    logic       intr;
    logic       pc_en;
  } ctl_t;

  localparam dec_t DEC_NOP = '{kind: K_NOP, reg_dst: 1'b0, alu_src: 1'b1, mem2reg: 1'b0,
                               op: 3'b010, branch: 1'b0, jump: 1'b0, bad: 1'b0};
  localparam ctl_t CTL_RST = '{op: 3'b010, default: 1'b0};

  // Unsupported opcode/funct decodes to a flagged NOP that retires in DECODE.
  function automatic dec_t decode(input logic [5:0] opc, input logic [5:0] fn);
    dec_t d;
    d = DEC_NOP;
    case (opc)
      6'h00: begin
        d.kind    = K_ALU;
        d.reg_dst = 1'b1;
        d.alu_src = 1'b0;
        case (fn)
          6'h20:   d.op = 3'b010;
          6'h22:   d.op = 3'b110;
          6'h24:   d.op = 3'b000;
          6'h25:   d.op = 3'b001;
          6'h2a:   d.op = 3'b111;
          default: begin
            d     = DEC_NOP;
            d.bad = 1'b1;
          end
        endcase
      end
      6'h23: begin
        d.kind    = K_LW;
        d.mem2reg = 1'b1;
      end
      6'h2b:   d.kind = K_SW;
      6'h04: begin
        d.kind    = K_BEQ;
        d.alu_src = 1'b0;
        d.op      = 3'b110;
        d.branch  = 1'b1;
      end
      6'h08:   d.kind = K_ALU;
      6'h02: begin
        d.kind = K_JUMP;
        d.jump = 1'b1;
      end
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

  function automatic state_e last_state(input kind_e k);
    case (k)
      K_NOP, K_JUMP: return S_DECODE;
      K_BEQ:         return S_EXEC;
      K_SW:          return S_MEM;
      default:       return S_WB;
    endcase
  endfunction

  state_e         state_q, state_d, after_retire;
  dec_t           dec_q, dec_d;
  ctl_t           ctl_q, ctl_d;
  logic           retire;
  logic [CNT_W:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, next decoded controls, and the outputs for the state being entered.
  always_comb begin
    retire       = 1'b0;
    state_d      = state_q;
    dec_d        = dec_q;
    ctl_d        = CTL_RST;
    cnt_inc      = {1'b0, ins_count} + CW1'(1);
    after_retire = (cnt_inc >= CW1'(MAX_INS)) ? S_DONE : S_FETCH;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})
      retire = (state_q == last_state(dec_q.kind));

    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_BOOT;
      S_BOOT:         state_d = S_FETCH;
      S_FETCH:        state_d = S_DECODE;
      S_DECODE:       state_d = retire ? after_retire : S_EXEC;
      S_EXEC: begin
        if (retire)                                 state_d = after_retire;
        else if (dec_q.kind inside {K_SW, K_LW})    state_d = S_MEM;
        else                                        state_d = S_WB;
      end
      S_MEM:          state_d = retire ? after_retire : S_WB;
      S_WB:           state_d = after_retire;
      default:        state_d = S_IDLE;
    endcase

    if (state_d == S_DECODE) dec_d = decode(bus.ins[31:26], bus.ins[5:0]);

    case (state_d)
      S_BOOT: begin
        ctl_d.intr  = 1'b1;
        ctl_d.pc_en = 1'b1;
      end
      S_FETCH: ctl_d.alu_src = 1'b1;
      S_DECODE, S_EXEC, S_MEM, S_WB: begin
        ctl_d.reg_dst   = dec_d.reg_dst;
        ctl_d.alu_src   = dec_d.alu_src;
        ctl_d.mem2reg   = dec_d.mem2reg;
        ctl_d.op        = dec_d.op;
        ctl_d.branch    = dec_d.branch;
        ctl_d.jump      = dec_d.jump;
        ctl_d.mem_read  = (state_d == S_MEM) && (dec_d.kind == K_LW);
        ctl_d.mem_write = (state_d == S_MEM) && (dec_d.kind == K_SW);
        ctl_d.reg_write = (state_d == S_WB);
        ctl_d.pc_en     = (state_d == last_state(dec_d.kind));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q     <= CTL_RST;
      dec_q     <= DEC_NOP;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      ins_count <= '0;
    end else begin
      ctl_q <= ctl_d;
      dec_q <= dec_d;
      busy  <= !(state_d inside {S_IDLE, S_DONE});
      done  <= (state_d == S_DONE);
      if (state_d == S_BOOT)                          illegal <= 1'b0;
      else if (state_d == S_DECODE && dec_d.bad)      illegal <= 1'b1;
      if (state_d == S_BOOT)                          ins_count <= '0;
      else if (retire && cnt_inc <= CW1'(MAX_INS))    ins_count <= cnt_inc[CNT_W-1:0];
    end
  end

  assign bus.RegDst     = ctl_q.reg_dst;
  assign bus.RegWrite   = ctl_q.reg_write;
  assign bus.ALUSrc     = ctl_q.alu_src;
  assign bus.Mem2Reg    = ctl_q.mem2reg;
  assign bus.MemRead    = ctl_q.mem_read;
  assign bus.MemWrite   = ctl_q.mem_write;
  assign bus.op         = ctl_q.op;
  assign bus.branch     = ctl_q.branch;
  assign bus.jump       = ctl_q.jump;
  assign bus.INT        = ctl_q.intr;
  assign bus.pc_en      = ctl_q.pc_en;
  assign bus.entryPoint = 32'(ENTRY_POINT);

endmodule
